// File: rtl/fdiv_pipe.sv
// fdiv_pipe: fully pipelined binary32 divider, q = a * (1/b).
// The reciprocal of b is formed at entry and travels through the same
// shift register as operand a, so both multiplier inputs arrive aligned.
// Special operands are classified at entry and override the product.
module fdiv_pipe #(
    parameter int INV_LAT = 2,
    parameter int OUT_REG = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             op_rcp,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      q,
    output logic             ovf,
    output logic             dz,
    output logic             nv
);

    localparam int DEPTH = INV_LAT + 1;

    typedef enum logic [2:0] {
        SC_NONE = 3'd0,
        SC_NAN  = 3'd1,
        SC_INV  = 3'd2,
        SC_DZ   = 3'd3,
        SC_INF  = 3'd4,
        SC_ZERO = 3'd5
    } special_e;

    // rExp is a biased exponent widened to 10 signed bits so reciprocals
    // of very large or very small divisors are not clipped before the multiply.
    // rMan holds 1.31 fixed point in [1,2).
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        special_e         code;
        logic [31:0]      a;
        logic             rSign;
        logic [9:0]       rExp;
        logic [31:0]      rMan;
    } stage_t;

    logic [31:0] w_aEff;
    logic        w_aNan, w_aInf, w_aZero;
    logic        w_bNan, w_bInf, w_bZero;
    special_e    w_code;
    logic [31:0] w_rcpQuot;
    logic        w_rcpPow2;
    stage_t      w_stageIn;
    stage_t      r_pipe [DEPTH];

    assign w_aEff  = op_rcp ? 32'h3F80_0000 : a;

    // Subnormals have a zero exponent field and therefore count as zero.
    assign w_aNan  = (&w_aEff[30:23]) & (|w_aEff[22:0]);
    assign w_aInf  = (&w_aEff[30:23]) & ~(|w_aEff[22:0]);
    assign w_aZero = ~(|w_aEff[30:23]);
    assign w_bNan  = (&b[30:23]) & (|b[22:0]);
    assign w_bInf  = (&b[30:23]) & ~(|b[22:0]);
    assign w_bZero = ~(|b[30:23]);

    // Special-case classification in priority order, highest first
    always_comb begin
        w_code = SC_NONE;
        if (w_aNan || w_bNan) begin
            w_code = SC_NAN;
        end else if ((w_aZero && w_bZero) || (w_aInf && w_bInf)) begin
            w_code = SC_INV;
        end else if (!w_aZero && !w_aInf && w_bZero) begin
            w_code = SC_DZ;
        end else if (w_aInf) begin
            w_code = SC_INF;
        end else if (w_bInf || w_aZero) begin
            w_code = SC_ZERO;
        end
    end

    // 2^55 / {1,frac} lands in (2^31, 2^32) for any non-power-of-two mantissa;
    // a power-of-two divisor has an exact reciprocal mantissa of 1.0.
    assign w_rcpQuot = 32'(56'h80_0000_0000_0000 / {32'd0, 1'b1, b[22:0]});
    assign w_rcpPow2 = ~(|b[22:0]);

    assign w_stageIn.valid = in_valid;
    assign w_stageIn.tag   = in_tag;
    assign w_stageIn.code  = w_code;
    assign w_stageIn.a     = w_aEff;
    assign w_stageIn.rSign = b[31];
    assign w_stageIn.rExp  = w_rcpPow2 ? (10'd254 - {2'b00, b[30:23]})
                                       : (10'd253 - {2'b00, b[30:23]});
    assign w_stageIn.rMan  = w_rcpPow2 ? 32'h8000_0000 : w_rcpQuot;

    // Operand, reciprocal, code, valid and tag shift together every cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_stageIn;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    stage_t      w_last;
    logic        w_sign;
    logic [55:0] w_prod;
    logic [25:0] w_prodHi;
    logic        w_top;
    logic [23:0] w_rnd;
    logic [11:0] w_mulExp;
    logic [31:0] w_mulQ;
    logic        w_mulOvf;
    logic [31:0] w_q;
    logic        w_ovf, w_dz, w_nv;

    assign w_last   = r_pipe[DEPTH-1];
    assign w_sign   = w_last.a[31] ^ w_last.rSign;
    assign w_prod   = {32'd0, 1'b1, w_last.a[22:0]} * {24'd0, w_last.rMan};
    assign w_prodHi = 26'(w_prod >> 30);
    assign w_top    = w_prodHi[25];
    // Round half-up on the first dropped bit; a carry out bumps the exponent
    assign w_rnd    = w_top ? ({1'b0, w_prodHi[24:2]} + {23'd0, w_prodHi[1]})
                            : ({1'b0, w_prodHi[23:1]} + {23'd0, w_prodHi[0]});
    assign w_mulExp = {4'b0000, w_last.a[30:23]}
                    + {{2{w_last.rExp[9]}}, w_last.rExp}
                    - 12'd127
                    + {11'd0, w_top}
                    + {11'd0, w_rnd[23]};

    // Multiplier result: overflow saturates to infinity, underflow flushes to zero
    always_comb begin
        w_mulQ   = {w_sign, w_mulExp[7:0], w_rnd[22:0]};
        w_mulOvf = 1'b0;
        if (w_last.a[30:23] == 8'd0) begin
            w_mulQ = {w_sign, 31'd0};
        end else if ($signed(w_mulExp) >= 12'sd255) begin
            w_mulQ   = {w_sign, 8'hFF, 23'd0};
            w_mulOvf = 1'b1;
        end else if ($signed(w_mulExp) <= 12'sd0) begin
            w_mulQ = {w_sign, 31'd0};
        end
    end

    // Final mux: a pipelined special-case code replaces the product
    always_comb begin
        w_q   = w_mulQ;
        w_ovf = w_mulOvf;
        w_dz  = 1'b0;
        w_nv  = 1'b0;
        case (w_last.code)
            SC_NAN:  begin w_q = 32'h7FC0_0000; w_ovf = 1'b0; end
            SC_INV:  begin w_q = 32'h7FC0_0000; w_ovf = 1'b0; w_nv = 1'b1; end
            SC_DZ:   begin w_q = {w_sign, 31'h7F80_0000}; w_ovf = 1'b0; w_dz = 1'b1; end
            SC_INF:  begin w_q = {w_sign, 31'h7F80_0000}; w_ovf = 1'b0; end
            SC_ZERO: begin w_q = {w_sign, 31'd0}; w_ovf = 1'b0; end
            default: ;
        endcase
    end

    generate
        if (OUT_REG != 0) begin : g_outReg
            logic             r_outValid;
            logic [TAG_W-1:0] r_outTag;
            logic [31:0]      r_q;
            logic             r_ovf, r_dz, r_nv;

            // Output register: one extra stage on result, flags, valid and tag
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_outValid <= 1'b0;
                    r_outTag   <= '0;
                    r_q        <= 32'd0;
                    r_ovf      <= 1'b0;
                    r_dz       <= 1'b0;
                    r_nv       <= 1'b0;
                end else begin
                    r_outValid <= w_last.valid;
                    r_outTag   <= w_last.tag;
                    r_q        <= w_q;
                    r_ovf      <= w_ovf;
                    r_dz       <= w_dz;
                    r_nv       <= w_nv;
                end
            end

            assign out_valid = r_outValid;
            assign out_tag   = r_outTag;
            assign q         = r_q;
            assign ovf       = r_ovf;
            assign dz        = r_dz;
            assign nv        = r_nv;
        end else begin : g_outComb
            assign out_valid = w_last.valid;
            assign out_tag   = w_last.tag;
            assign q         = w_q;
            assign ovf       = w_ovf;
            assign dz        = w_dz;
            assign nv        = w_nv;
        end
    endgenerate

endmodule

// File: doc/fdiv_pipe.md
Name: fdiv_pipe

Overview:
Parametrised, fully pipelined single-precision divider for the FPU datapath, successor to the fixed 200 MHz divider. It computes q = a × (1/b) using the existing finv_200 reciprocal unit and the fmul_for_fdiv multiplier. It adds:
- valid/tag sideband
- reciprocal-only mode
- configurable output register
- IEEE special-case override
- sticky-free per-result exception flags

It accepts one operation per cycle, with no backpressure.

Parameters:
INV_LAT, 2, latency in cycles of the reciprocal unit; the operand-a delay line depth equals INV_LAT+1.
OUT_REG, 1, 1 = register q/flags/valid/tag at the output; 0 = multiplier output is combinational from the last stage.
TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  operation present this cycle
in_tag  input  TAG_W  sideband returned with the result
op_rcp  input  1  1 = compute 1/b (a ignored, treated as 0x3F800000)
a  input  32  dividend, IEEE-754 binary32
b  input  32  divisor, IEEE-754 binary32
out_valid  output  1  result valid
out_tag  output  TAG_W  tag of the result
q  output  32  quotient
ovf  output  1  exponent overflow from the multiply (masked on special cases)
dz  output  1  divide-by-zero (finite nonzero a, zero b)
nv  output  1  invalid operation (0/0, inf/inf)

Behaviour:
- Latency L = INV_LAT + 1 + OUT_REG cycles from in_valid sample to out_valid (default 4).
- Throughput is 1 per cycle. The pipeline always advances; there is no stall or ready.
- Reset (rstn low, asynchronous) clears all pipeline registers, including valid bits, tags, a-delay, reciprocal register and special-case codes. Outputs read 0: out_valid=0, q=0, out_tag=0, ovf=dz=nv=0.
- Reset release mid-stream: in-flight operations are discarded. The first out_valid occurs L cycles after the first in_valid sampled with rstn high.
- Operand a (or 1.0 when op_rcp) is delayed INV_LAT+1 stages. The reciprocal output is registered once, so both multiplier inputs align.
- Valid and tag travel in a parallel shift register of the same depth.
- q, flags and tag are updated every cycle regardless of valid. The bench checks them only when out_valid=1.
- Special-case classification is done at input from a_eff and b. The 3-bit code is pipelined alongside the data, and the final mux overrides the multiplier result. Subnormal inputs are treated as zero of the same sign.
- Result sign s = sign(a_eff) XOR sign(b). Override rules, highest priority first:
  1. a or b NaN → q=0x7FC00000, nv=0
  2. 0/0 or inf/inf → q=0x7FC00000, nv=1
  3. finite nonzero a / zero b → q={s,0x7F800000[30:0]}, dz=1
  4. inf / finite → signed inf
  5. finite / inf, or zero / nonzero finite → signed zero {s,31'b0}
- On any override, ovf=0. Otherwise q and ovf come from the multiplier unchanged, and dz=nv=0.
- in_valid=0 cycles insert bubbles. out_valid follows the same bubble pattern L cycles later.

Test Plan:
- 6.0/2.0: a=0x40C00000, b=0x40000000, in_tag=3 → after 4 cycles out_valid=1, q=0x40400000, out_tag=3, flags 0.
- op_rcp=1, b=0x40800000 (4.0), a=0xDEADBEEF → q=0x3E800000, no flags.
- 1.0/0.0 → q=0x7F800000, dz=1. -1.0/+0.0 → q=0xFF800000, dz=1. 0/0 → q=0x7FC00000, nv=1.
- Overflow: a=0x7F000000, b=0x3E800000 → ovf=1. Then NaN a=0x7FC00001, b=1.0 → q=0x7FC00000, ovf=0.
- Stream 8 back-to-back ops with tags 0..7 and one bubble after tag 3 → results in order, one-cycle gap in out_valid, each q matching a golden model within 1 ulp.
- Assert rstn low for 1 cycle while 3 ops are in flight → outputs 0 immediately, no out_valid for the flushed ops. A new op issued after release appears exactly L cycles later.
